wam_gen: RTL
============

WAM_GEN -- requirements
Module: wam_gen

Interface
REQ-001 SHALL have parameter NHOLE, default 8, meaning number of mole holes; only 8 is supported (index is 3 bits).
REQ-002 SHALL have port clk_19  input  1  game clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port run  input  1  game active; 0 freezes spawning and ageing.
REQ-005 SHALL have port tck  input  1  one-cycle step pulse; one mole-age unit.
REQ-006 SHALL have port age  input  4  mole lifetime in tck steps, from difficulty parameter stage.
REQ-007 SHALL have port rto  input  8  spawn threshold per tck, from difficulty parameter stage.
REQ-008 SHALL have port hit  input  8  debounced one-cycle press pulse per hole.
REQ-009 SHALL have port mol  output  8  bit i = 1 while a mole occupies hole i.
REQ-010 SHALL have port hit_p  output  1  one-cycle pulse: a mole was whacked.
REQ-011 SHALL have port mis_p  output  1  one-cycle pulse: a mole expired unwhacked.
REQ-012 SHALL have port wrg_p  output  1  one-cycle pulse: an empty hole was pressed.

Function
REQ-013 SHALL hold an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, advancing every clk_19 cycle regardless of run.
REQ-014 SHALL hold per hole a 4-bit life counter; a hole is occupied iff its counter is nonzero, and mol[i] SHALL be registered from that.
REQ-015 SHALL spawn, on a cycle with run=1 and tck=1, at most one mole: candidate index = {lfsr[7],lfsr[3],lfsr[0]}, spawn iff lfsr[6:0] < rto and the candidate hole is empty before that cycle.
REQ-016 SHALL load the spawned hole's counter with age, latched at spawn; later age/rto changes SHALL NOT affect live moles.
REQ-017 SHALL load age=0 as 1, never as 0 (minimum lifetime one tck).
REQ-018 SHALL, on run=1 and tck=1, decrement every occupied counter not spawned that cycle; a counter going 1->0 without a same-cycle hit SHALL assert mis_p.
REQ-019 SHALL assert mis_p at most once per cycle even if several moles expire together; count loss is accepted.
REQ-020 SHALL evaluate hit against the pre-cycle occupancy: hit[i] on occupied hole clears its counter to 0 and asserts hit_p; hit[i] on empty hole asserts wrg_p.
REQ-021 SHALL treat multiple hit bits in one cycle per hole, ORing results into hit_p/wrg_p.
REQ-022 SHALL give hit priority over expiry on the same hole in the same cycle (hit_p=1, mis_p=0).
REQ-023 SHALL, when spawn and hit target the same empty hole in one cycle, assert wrg_p and still spawn.
REQ-024 SHALL process hit only while run=1; with run=0, hits are ignored and no pulses are produced.
REQ-025 SHALL register all outputs; pulses appear the cycle after the causing input edge, one cycle wide.
REQ-026 SHALL NOT clear moles when run falls; occupancy is frozen until run returns or reset.

Reset
REQ-027 SHALL, on rst=1, asynchronously set all counters to 0, mol=0, hit_p=mis_p=wrg_p=0, LFSR=8'hA5.
REQ-028 SHALL, on rst asserted mid-game, drop all live moles without asserting mis_p.
REQ-029 SHALL resume normal operation on the first clk_19 edge after rst deasserts.

Structure
REQ-030 SHALL place LFSR seed 8'hA5, tap set and NHOLE in the shared wam constants package, also used by the difficulty stage.
REQ-031 SHALL use one sub-module, wam_lfsr (8-bit, seed on reset, advance every cycle, parallel output); the per-hole counters SHALL be a generate loop in wam_gen.

Verification
REQ-032 SHALL cover: rto=0, run=1, 200 tck pulses -> mol stays 8'h00, no pulses.
REQ-033 SHALL cover: rto=255, age=7, one tck -> exactly one mol bit set at the LFSR-predicted index; after 7 further tck with no hit it clears and mis_p pulses once.
REQ-034 SHALL cover: mole live in hole 3, hit=8'h08 -> next cycle mol[3]=0, hit_p=1 for one cycle; hit=8'h10 on empty hole 4 -> wrg_p=1.
REQ-035 SHALL cover: mole with counter 1, hit on the same cycle as tck -> hit_p=1, mis_p=0.
REQ-036 SHALL cover: age changed 7->14 while a mole lives -> it still expires after its original 7 tck.
REQ-037 SHALL cover: rst pulsed with 3 live moles -> mol=8'h00 immediately (asynchronous), no mis_p, LFSR back to 8'hA5.

Source files
------------

// File: rtl/wam_pkg.sv
// Shared whack-a-mole constants: hole count, LFSR seed and feedback taps.
`default_nettype none

package wam_pkg;

  localparam int unsigned c_nhole = 8;

  // x^8+x^6+x^5+x^4+1 on a left-shifting register: taps at bits 7,5,4,3.
  localparam logic [7:0] c_lfsr_seed = 8'hA5;
  localparam logic [7:0] c_lfsr_taps = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & c_lfsr_taps)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/wam_lfsr.sv
// 8-bit Fibonacci LFSR, seeded on reset, advancing every clock.
`default_nettype none

module wam_lfsr
  import wam_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d  = lfsr_next(lfsr_q);
  assign state_o = lfsr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= c_lfsr_seed;
    else       lfsr_q <= lfsr_d;
  end

endmodule

`default_nettype wire

// File: rtl/wam_gen.sv
// Mole generator: random spawning, per-hole lifetime counters, hit/miss/wrong pulses.
`default_nettype none

module wam_gen
  import wam_pkg::*;
#(
  parameter int NHOLE = c_nhole
) (
  input  logic             clk_19,
  input  logic             rst,
  input  logic             run,
  input  logic             tck,
  input  logic [3:0]       age,
  input  logic [7:0]       rto,
  input  logic [NHOLE-1:0] hit,
  output logic [NHOLE-1:0] mol,
  output logic             hit_p,
  output logic             mis_p,
  output logic             wrg_p
);

  logic [7:0]       w_lfsr;
  logic             w_step;
  logic [2:0]       w_cand;
  logic [3:0]       w_age;
  logic             w_spawn_ok;
  logic [NHOLE-1:0] w_occ;
  logic [NHOLE-1:0] w_occ_nxt;
  logic [NHOLE-1:0] w_hh;
  logic [NHOLE-1:0] w_wh;
  logic [NHOLE-1:0] w_mh;

  logic [NHOLE-1:0] mol_q;
  logic             hit_p_q;
  logic             mis_p_q;
  logic             wrg_p_q;

  wam_lfsr u_lfsr (
    .clk_i   (clk_19),
    .rst_i   (rst),
    .state_o (w_lfsr)
  );

  assign w_step     = run & tck;
  assign w_cand     = {w_lfsr[7], w_lfsr[3], w_lfsr[0]};
  assign w_age      = (age == 4'd0) ? 4'd1 : age;
  // Occupancy here is the pre-cycle view, so a hole hit this cycle still blocks a spawn.
  assign w_spawn_ok = w_step && ({1'b0, w_lfsr[6:0]} < rto) && !w_occ[w_cand];

  for (genvar i = 0; i < NHOLE; i++) begin : g_hole
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       hit_i;
    logic       spn_i;
    logic       hh;
    logic       wh;
    logic       mh;

    assign hit_i = run & hit[i];
    assign spn_i = w_spawn_ok && (w_cand == 3'(i));

    always_comb begin
      cnt_d = cnt_q;
      hh    = 1'b0;
      wh    = 1'b0;
      mh    = 1'b0;
      if (hit_i && (cnt_q != 4'd0)) begin
        cnt_d = 4'd0;
        hh    = 1'b1;
      end else begin
        wh = hit_i;
        if (spn_i) begin
          cnt_d = w_age;
        end else if (w_step && (cnt_q != 4'd0)) begin
          cnt_d = cnt_q - 4'd1;
          mh    = (cnt_q == 4'd1);
        end
      end
    end

    always_ff @(posedge clk_19 or posedge rst) begin
      if (rst) cnt_q <= 4'd0;
      else     cnt_q <= cnt_d;
    end

    assign w_occ[i]     = (cnt_q != 4'd0);
    assign w_occ_nxt[i] = (cnt_d != 4'd0);
    assign w_hh[i]      = hh;
    assign w_wh[i]      = wh;
    assign w_mh[i]      = mh;
  end

  always_ff @(posedge clk_19 or posedge rst) begin
    if (rst) begin
      mol_q   <= '0;
      hit_p_q <= 1'b0;
      mis_p_q <= 1'b0;
      wrg_p_q <= 1'b0;
    end else begin
      mol_q   <= w_occ_nxt;
      hit_p_q <= |w_hh;
      mis_p_q <= |w_mh;
      wrg_p_q <= |w_wh;
    end
  end

  assign mol   = mol_q;
  assign hit_p = hit_p_q;
  assign mis_p = mis_p_q;
  assign wrg_p = wrg_p_q;

endmodule

`default_nettype wire
